// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It also runs the halt/drain/resume state machine and the performance counters.
module pipe_hazard_ctrl #(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic             halt_req,
   input  logic             mem_busy,
   input  logic             go,
   input  logic             clr_cnt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_en,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t        state, state_nx;
   logic [DW-1:0] drain, drain_nx;
   logic          go_q, bubble, flush;

   always_comb begin
      state_nx   = state;
      drain_nx   = drain;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      pipe_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = state == HALTED;
      bubble     = 1'b0;
      flush      = 1'b0;
      if (mem_busy) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         pipe_en = 1'b0;
      end else begin
         case (state)
            RUN: begin
               // younger hazards are squashed by a taken branch
               if (branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  flush      = 1'b1;
               end else if (load_use) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  bubble     = 1'b1;
               end else if (jump) begin
                  ifid_flush = 1'b1;
                  flush      = 1'b1;
               end else if (halt_req) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  ifid_flush = 1'b1;
                  drain_nx   = DW'(DRAIN_CYCLES - 1);
                  if (DRAIN_CYCLES == 1) state_nx = HALTED;
                  else state_nx = DRAIN;
               end
            end
            DRAIN: begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
               if (drain == '0) state_nx = HALTED;
               else drain_nx = drain - DW'(1);
            end
            HALTED: begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               pipe_en = 1'b0;
               if (go && !go_q) state_nx = RUN;
            end
            default: state_nx = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         drain      <= '0;
         go_q       <= 1'b0;
         cycle_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         state <= state_nx;
         drain <= drain_nx;
         go_q  <= go;
         if (clr_cnt) begin
            cycle_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
         end else begin
            cycle_cnt  <= cycle_cnt + CNT_W'(state != HALTED);
            bubble_cnt <= bubble_cnt + CNT_W'(bubble);
            flush_cnt  <= flush_cnt + CNT_W'(flush);
         end
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus for pipe_hazard_ctrl.
// An abstract model in the bench predicts every output each cycle.
module tb_pipe_hazard_ctrl;
   localparam int DC = 3;

   logic clk = 1'b0, rst_n = 1'b0;
   logic load_use = 0, branch_taken = 0, jump = 0, halt_req = 0, mem_busy = 0, go = 0, clr_cnt = 0;
   logic pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, halted;
   logic [31:0] cycle_cnt, bubble_cnt, flush_cnt;

   int n_chk = 0, n_pass = 0;

   pipe_hazard_ctrl #(.CNT_W(32), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
      .jump(jump), .halt_req(halt_req), .mem_busy(mem_busy), .go(go), .clr_cnt(clr_cnt),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .pipe_en(pipe_en), .halted(halted), .cycle_cnt(cycle_cnt), .bubble_cnt(bubble_cnt),
      .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // model: mode 0=running, 1=draining, 2=halted; left = drain cycles still owed
   int          mode = 0, left = 0;
   bit          m_goq = 0;
   logic [31:0] m_cyc = 0, m_bub = 0, m_fl = 0;

   initial forever begin
      logic [5:0] e;
      int         mode_n, left_n;
      bit         bub_inc, fl_inc;
      @(negedge clk);
      #2;
      if (!rst_n) begin
         mode = 0; left = 0; m_goq = 0; m_cyc = 0; m_bub = 0; m_fl = 0;
      end
      e = {5'b11001, mode == 2};
      mode_n = mode; left_n = left; bub_inc = 0; fl_inc = 0;
      if (mem_busy) e[5:1] = 5'b00000;
      else if (mode == 0) begin
         if (branch_taken) begin e[5:1] = 5'b11111; fl_inc = 1; end
         else if (load_use) begin e[5:1] = 5'b00011; bub_inc = 1; end
         else if (jump) begin e[5:1] = 5'b11101; fl_inc = 1; end
         else if (halt_req) begin
            e[5:1] = 5'b00101;
            if (DC == 1) mode_n = 2;
            else begin mode_n = 1; left_n = DC; end
         end
      end else if (mode == 1) begin
         e[5:1] = 5'b00011;
         left_n = left - 1;
         if (left_n == 0) mode_n = 2;
      end else begin
         e[5:1] = 5'b00000;
         if (go && !m_goq) mode_n = 0;
      end
      chk("ctrl", {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, halted}, e);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("bubble_cnt", bubble_cnt, m_bub);
      chk("flush_cnt", flush_cnt, m_fl);
      if (rst_n) begin
         if (clr_cnt) begin m_cyc = 0; m_bub = 0; m_fl = 0; end
         else begin
            m_cyc += 32'(mode != 2);
            m_bub += 32'(bub_inc);
            m_fl  += 32'(fl_inc);
         end
         m_goq = go; mode = mode_n; left = left_n;
      end
   end

   task automatic drive(input logic lu, br, jp, hr, mb, g, cl);
      @(negedge clk);
      load_use = lu; branch_taken = br; jump = jp; halt_req = hr; mem_busy = mb; go = g; clr_cnt = cl;
   endtask

   initial begin
      @(negedge clk);
      #3;
      chk("rst_pc_en", pc_en, 1);
      chk("rst_pipe_en", pipe_en, 1);
      chk("rst_cycle", cycle_cnt, 0);
      @(negedge clk) rst_n = 1;
      repeat (10) drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("idle_cycle", cycle_cnt, 10);
      chk("idle_flush", flush_cnt, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      #3 chk("lu_ctrl", {pc_en, ifid_en, idex_flush}, 3'b001);
      drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("lu_after_pc", pc_en, 1);
      chk("lu_bubble", bubble_cnt, 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 1, 0, 0, 0, 0);
      #3 chk("br_ctrl", {pc_en, ifid_flush, idex_flush}, 3'b111);
      drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("br_flush", flush_cnt, 1);
      chk("br_bubble", bubble_cnt, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      #3 chk("halt_acc", {pc_en, ifid_flush, idex_flush}, 3'b010);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         #3 chk("drain_ctrl", {halted, idex_flush}, 2'b01);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("halted", halted, 1);
      repeat (4) drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      #3 chk("go_edge_still", halted, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("resumed", halted, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0, 1, 0);
      repeat (20) drive(0, 0, 0, 0, 0, 1, 0);
      #3 chk("go_held_once", halted, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      #3 chk("resume2", halted, 0);
      repeat (4) begin
         drive(0, 0, 0, 0, 1, 0, 0);
         #3 chk("busy_ctrl", {pc_en, ifid_en, pipe_en, idex_flush}, 4'b0000);
      end
      repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("busy_drain_late", halted, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("busy_halted", halted, 1);
      @(negedge clk) rst_n = 0;
      #3 chk("async_rst", {pc_en, ifid_en, pipe_en, halted}, 4'b1110);
      chk("async_rst_cnt", cycle_cnt, 0);
      @(negedge clk) rst_n = 1;
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      #3 chk("clr_prio", bubble_cnt, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            rst_n = 0;
            @(negedge clk) rst_n = 1;
         end
         drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 10,
               ($urandom_range(0, 4) == 0) ? ~go : go, $urandom_range(0, 99) < 2);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #5 $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
